gppcu_scoreboard: RTL and testbench
===================================

# gppcu_scoreboard

Multi-writeback register scoreboard for the GPPCU issue stage. It tracks outstanding writes per destination register with saturating counters, so one register can have several writes in flight. It resolves RAW hazards on two source operands and gates issue when a destination counter is full. It accepts up to NUMWB retirements per cycle and has same-cycle writeback bypass, flush, an error flag and a stall statistic.

## Interface
- NUMREG, 32, number of architectural registers; RBW = bit width needed for NUMREG-1 (minimum 1)
- NUMWB, 2, number of writeback ports retiring per cycle (1..4)
- CNTW, 2, width of each per-register outstanding-write counter (max pending = 2^CNTW-1)
- ZERO_REG, 1, when 1 register 0 is never tracked: always hazard-free, issues/writebacks to it ignored
- STW, 16, width of stall statistic counter

- iACLK  in  1  clock, rising edge
- inRST  in  1  reset, asynchronous, active-low
- iISSUE  in  1  instruction presented for issue this cycle
- iREGD  in  RBW  destination register
- iVALID_REGD  in  1  instruction writes iREGD
- iREGA / iREGB  in  RBW  source registers
- iVALID_REGA / iVALID_REGB  in  1  source operand used
- oENABLED  out  1  combinational; no hazard for presented operands; issue accepted = iISSUE & oENABLED
- iWRREG  in  NUMWB*RBW  writeback register per port, port k at bits [k*RBW +: RBW]
- iWRREG_VALID  in  NUMWB  writeback valid per port
- iFLUSH  in  1  synchronous clear of all pending state
- oBUSY  out  1  registered; any counter nonzero
- oERR  out  1  registered sticky; writeback underflow seen
- oSTALL_CNT  out  STW  cycles with iISSUE & !oENABLED, saturating

## Operation
- Per register r: cnt[r] (CNTW bits). hits[r] = number of valid WB ports with iWRREG==r (0..NUMWB).
- eff[r] = cnt[r] - hits[r], clamped at 0.
- Source hazard: valid source s with eff[s] > 0. Bypass only when the retirement empties the counter (count 1 + one hit → no stall). Count 2 + one hit → stall.
- Destination hazard: iVALID_REGD and eff[D] == 2^CNTW-1 (counter would overflow).
- oENABLED = !iFLUSH & no source hazard & no destination hazard. Computed regardless of iISSUE.
- Issue increments when iISSUE & oENABLED & iVALID_REGD: inc[D] = 1.
- Next-state: cnt[r] <= eff[r] + inc[r].
- Simultaneous issue and writeback to the same register is legal; both apply in the same cycle.
- Underflow: hits[r] > cnt[r] sets oERR. The counter clamps at 0 and oERR stays set until reset.
- Duplicate WB ports to the same register in one cycle count as multiple retirements.
- ZERO_REG=1: r=0 is always hazard-free, cnt[0] stays 0, and writebacks to r=0 never set oERR.
- Register indices >= NUMREG: any source/dest/WB index >= NUMREG is ignored; it is hazard-free and causes no count change.
- iFLUSH: all cnt <= 0 next edge. Writebacks and issue in that cycle are discarded; oERR is not updated; oENABLED = 0.
- oSTALL_CNT increments on each cycle with iISSUE & !oENABLED (including flush cycles) and saturates at 2^STW-1.
- oBUSY <= OR of next-state counters.

## Timing
- Reset (inRST low, async) clears, without waiting for a clock edge: all cnt, oBUSY, oERR and oSTALL_CNT go to 0.
- Release is synchronous to the next iACLK edge.
- oENABLED is purely combinational from current inputs and counters; zero-cycle latency.
- Counter updates take effect on the rising edge after acceptance. A dependent instruction presented the next cycle sees the hazard.
- Writeback bypass is same-cycle: a source whose last pending write retires in cycle N can issue in cycle N.
- oBUSY and oERR reflect state one cycle after the causing event.
- Reset asserted mid-operation discards all pending state; the first post-reset cycle sees oENABLED = 1 for any operands.

## Test plan
- Reset, then issue D=5 (cycle 0), then A=5 at cycle 1 with no WB → oENABLED=0; WB port0 r5 at cycle 3 with A=5 presented → oENABLED=1 that cycle; cnt[5]=0 after; oSTALL_CNT=2.
- WAW with CNTW=2: issue D=7 three times → cnt[7]=3; 4th issue D=7 → oENABLED=0. The same with one WB r7 present → accepted, cnt stays 3.
- Dual WB: cnt[3]=2, both ports retire r3 in one cycle while A=3 presented → oENABLED=1, cnt[3]=0; cnt[3]=2 with one port only → stall.
- Underflow: WB r9 with cnt[9]=0 → cnt stays 0, oERR=1 next cycle and stays 1; WB r0 with ZERO_REG=1 → oERR unchanged.
- Flush: cnt[4]=1, cnt[6]=2, assert iFLUSH with iISSUE → oENABLED=0, oSTALL_CNT+1; next cycle all counts 0, oBUSY=0.
- Async reset mid-run: drop inRST between clock edges with oBUSY=1, oERR=1 → both 0 immediately, before any iACLK edge; oSTALL_CNT=0.

Source files
------------

// File: rtl/gppcu_scoreboard.sv
// rtl/gppcu_scoreboard.sv - multi-writeback register scoreboard for the GPPCU issue stage
module gppcu_scoreboard #(
  parameter int NUMREG   = 32,
  parameter int NUMWB    = 2,
  parameter int CNTW     = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter int STW      = 16,
  localparam int RBW     = (NUMREG > 1) ? $clog2(NUMREG) : 1
) (
  input  logic                 iACLK,
  input  logic                 inRST,
  input  logic                 iISSUE,
  input  logic [RBW-1:0]       iREGD,
  input  logic                 iVALID_REGD,
  input  logic [RBW-1:0]       iREGA,
  input  logic                 iVALID_REGA,
  input  logic [RBW-1:0]       iREGB,
  input  logic                 iVALID_REGB,
  output logic                 oENABLED,
  input  logic [NUMWB*RBW-1:0] iWRREG,
  input  logic [NUMWB-1:0]     iWRREG_VALID,
  input  logic                 iFLUSH,
  output logic                 oBUSY,
  output logic                 oERR,
  output logic [STW-1:0]       oSTALL_CNT
);

  // hits needs to hold 0..NUMWB; eff/underflow math is done in the wider of the two widths
  localparam int HW = $clog2(NUMWB + 1);
  localparam int EW = (CNTW > HW) ? CNTW : HW;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0]   cnt     [NUMREG];
  logic [CNTW-1:0]   cntNext [NUMREG];
  logic [CNTW-1:0]   eff     [NUMREG];
  logic [HW-1:0]     hits    [NUMREG];
  logic [NUMREG-1:0] underflow;
  logic              hazA, hazB, hazD;
  logic              acceptD;
  logic              busyNext;

  // register 0 is hardwired free when ZERO_REG is set; indices past NUMREG never match any r
  function automatic logic isTracked(input int r);
    return !(ZERO_REG && (r == 0));
  endfunction

  // count retirements per register and derive the post-writeback (bypassed) count
  always_comb begin
    underflow = '0;
    for (int r = 0; r < NUMREG; r++) begin
      hits[r] = '0;
      eff[r]  = '0;
      for (int k = 0; k < NUMWB; k++) begin
        if (iWRREG_VALID[k] && (iWRREG[k*RBW +: RBW] == RBW'(r))) begin
          hits[r] = hits[r] + HW'(1);
        end
      end
      if (isTracked(r)) begin
        if (EW'(hits[r]) > EW'(cnt[r])) begin
          underflow[r] = 1'b1;
        end else begin
          eff[r] = CNTW'(EW'(cnt[r]) - EW'(hits[r]));
        end
      end
    end
  end

  // source RAW hazards use the bypassed count; the destination hazard guards counter overflow
  always_comb begin
    hazA = 1'b0;
    hazB = 1'b0;
    hazD = 1'b0;
    for (int r = 0; r < NUMREG; r++) begin
      if (isTracked(r)) begin
        if (iVALID_REGA && (iREGA == RBW'(r)) && (eff[r] != '0))    hazA = 1'b1;
        if (iVALID_REGB && (iREGB == RBW'(r)) && (eff[r] != '0))    hazB = 1'b1;
        if (iVALID_REGD && (iREGD == RBW'(r)) && (eff[r] == CNT_MAX)) hazD = 1'b1;
      end
    end
  end

  assign oENABLED = !iFLUSH && !hazA && !hazB && !hazD;
  assign acceptD  = iISSUE && oENABLED && iVALID_REGD;

  // next counter state: flush wins, otherwise retire then add the accepted issue
  always_comb begin
    busyNext = 1'b0;
    for (int r = 0; r < NUMREG; r++) begin
      cntNext[r] = '0;
      if (!iFLUSH && isTracked(r)) begin
        cntNext[r] = eff[r] + CNTW'(acceptD && (iREGD == RBW'(r)));
      end
      busyNext = busyNext | (cntNext[r] != '0);
    end
  end

  // state, busy, sticky error and saturating stall statistic
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      cnt        <= '{default: '0};
      oBUSY      <= 1'b0;
      oERR       <= 1'b0;
      oSTALL_CNT <= '0;
    end else begin
      cnt   <= cntNext;
      oBUSY <= busyNext;
      if (!iFLUSH && (underflow != '0)) begin
        oERR <= 1'b1;
      end
      if (iISSUE && !oENABLED && (oSTALL_CNT != '1)) begin
        oSTALL_CNT <= oSTALL_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gppcu_scoreboard.sv
// tb/tb_gppcu_scoreboard.sv - directed scoreboard bench for gppcu_scoreboard
module tb_gppcu_scoreboard;

  localparam int RBW   = 5;
  localparam int NUMWB = 2;

  logic             iACLK;
  logic             inRST;
  logic             iISSUE;
  logic [RBW-1:0]   iREGD, iREGA, iREGB;
  logic             iVALID_REGD, iVALID_REGA, iVALID_REGB;
  logic             oENABLED;
  logic [NUMWB*RBW-1:0] iWRREG;
  logic [NUMWB-1:0] iWRREG_VALID;
  logic             iFLUSH;
  logic             oBUSY;
  logic             oERR;
  logic [15:0]      oSTALL_CNT;

  int vectors = 0;
  int miscompares = 0;

  logic        enQ   [$];
  logic [1:0]  postQ [$];

  gppcu_scoreboard dut (
    .iACLK(iACLK), .inRST(inRST), .iISSUE(iISSUE),
    .iREGD(iREGD), .iVALID_REGD(iVALID_REGD),
    .iREGA(iREGA), .iVALID_REGA(iVALID_REGA),
    .iREGB(iREGB), .iVALID_REGB(iVALID_REGB),
    .oENABLED(oENABLED), .iWRREG(iWRREG), .iWRREG_VALID(iWRREG_VALID),
    .iFLUSH(iFLUSH), .oBUSY(oBUSY), .oERR(oERR), .oSTALL_CNT(oSTALL_CNT)
  );

  initial iACLK = 1'b0;
  always #5 iACLK = ~iACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iISSUE = 0; iFLUSH = 0;
    iREGD = '0; iREGA = '0; iREGB = '0;
    iVALID_REGD = 0; iVALID_REGA = 0; iVALID_REGB = 0;
    iWRREG = '0; iWRREG_VALID = '0;
  endtask

  task automatic wb(input int port, input int r);
    iWRREG[port*RBW +: RBW] = RBW'(r);
    iWRREG_VALID[port] = 1'b1;
  endtask

  // entered at posedge+1 with inputs set; checks oENABLED mid-cycle, busy/err after the edge
  task automatic tick(input string tag, input logic expEn, input logic expBusy, input logic expErr);
    logic [1:0] p;
    enQ.push_back(expEn);
    postQ.push_back({expBusy, expErr});
    #2;
    compare({tag, ".en"}, 32'(oENABLED), 32'(enQ.pop_front()));
    @(posedge iACLK); #1;
    p = postQ.pop_front();
    compare({tag, ".busy"}, 32'(oBUSY), 32'(p[1]));
    compare({tag, ".err"},  32'(oERR),  32'(p[0]));
    idle();
  endtask

  initial begin
    inRST = 0;
    idle();
    repeat (2) @(posedge iACLK);
    #1;
    compare("reset.busy", 32'(oBUSY), 0);
    compare("reset.err", 32'(oERR), 0);
    compare("reset.stall", 32'(oSTALL_CNT), 0);
    #2 inRST = 1;
    @(posedge iACLK); #1;

    // RAW hazard and same-cycle bypass
    iISSUE = 1; iVALID_REGD = 1; iREGD = 5; tick("raw.issue", 1, 1, 0);
    iISSUE = 1; iVALID_REGA = 1; iREGA = 5; tick("raw.stall1", 0, 1, 0);
    iISSUE = 1; iVALID_REGA = 1; iREGA = 5; tick("raw.stall2", 0, 1, 0);
    iISSUE = 1; iVALID_REGA = 1; iREGA = 5; wb(0, 5); tick("raw.bypass", 1, 0, 0);
    compare("raw.stallcnt", 32'(oSTALL_CNT), 2);
    iISSUE = 1; iVALID_REGA = 1; iREGA = 5; tick("raw.cleared", 1, 0, 0);

    // WAW saturation of a 2-bit counter
    for (int i = 0; i < 3; i++) begin
      iISSUE = 1; iVALID_REGD = 1; iREGD = 7; tick("waw.fill", 1, 1, 0);
    end
    iISSUE = 1; iVALID_REGD = 1; iREGD = 7; tick("waw.full", 0, 1, 0);
    iISSUE = 1; iVALID_REGD = 1; iREGD = 7; wb(0, 7); tick("waw.retire", 1, 1, 0);
    iISSUE = 1; iVALID_REGD = 1; iREGD = 7; tick("waw.still_full", 0, 1, 0);
    compare("waw.stallcnt", 32'(oSTALL_CNT), 4);
    wb(0, 7); wb(1, 7); tick("waw.drain2", 1, 1, 0);
    iVALID_REGA = 1; iREGA = 7; wb(1, 7); tick("waw.drain1", 1, 0, 0);

    // dual writeback ports
    for (int i = 0; i < 2; i++) begin
      iISSUE = 1; iVALID_REGD = 1; iREGD = 3; tick("dual.fill", 1, 1, 0);
    end
    iISSUE = 1; iVALID_REGA = 1; iREGA = 3; wb(0, 3); wb(1, 3); tick("dual.both", 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      iISSUE = 1; iVALID_REGD = 1; iREGD = 3; tick("dual.refill", 1, 1, 0);
    end
    iISSUE = 1; iVALID_REGB = 1; iREGB = 3; wb(1, 3); tick("dual.one", 0, 1, 0);
    wb(1, 3); tick("dual.drain", 1, 0, 0);
    compare("dual.stallcnt", 32'(oSTALL_CNT), 5);

    // register zero and underflow
    iISSUE = 1; iVALID_REGD = 1; iREGD = 0; iVALID_REGA = 1; iVALID_REGB = 1;
    wb(0, 0); wb(1, 0); tick("zero", 1, 0, 0);
    wb(0, 9); tick("under.set", 1, 0, 1);
    tick("under.sticky", 1, 0, 1);

    // flush
    iISSUE = 1; iVALID_REGD = 1; iREGD = 4; tick("flush.fill4", 1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      iISSUE = 1; iVALID_REGD = 1; iREGD = 6; tick("flush.fill6", 1, 1, 1);
    end
    iFLUSH = 1; iISSUE = 1; iVALID_REGD = 1; iREGD = 8; wb(0, 6); tick("flush", 0, 0, 1);
    compare("flush.stallcnt", 32'(oSTALL_CNT), 6);
    iISSUE = 1; iVALID_REGA = 1; iREGA = 4; iVALID_REGB = 1; iREGB = 6;
    iVALID_REGD = 1; iREGD = 6; tick("flush.clear", 1, 1, 1);

    // asynchronous reset between edges
    #2 inRST = 0;
    #1;
    compare("areset.busy", 32'(oBUSY), 0);
    compare("areset.err", 32'(oERR), 0);
    compare("areset.stall", 32'(oSTALL_CNT), 0);
    #2 inRST = 1;
    @(posedge iACLK); #1;
    iISSUE = 1; iVALID_REGA = 1; iREGA = 6; iVALID_REGD = 1; iREGD = 6;
    tick("post_reset", 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
